// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback path and branch unit.
// Condition codes follow the ARM cond field encoding.
package alu_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation against an NZCV value.
// Shared between the ALU writeback stage and the branch unit.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Conditional writeback after the ALU: NZCV commit, squash counting
// and a 2-entry register-file write buffer.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_flag,
    input  logic [3:0]        in_cond,
    input  logic              in_setflags,
    input  logic              in_wen,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic [3:0]        nzcv,
    output logic [CNT_W-1:0]  skip_count
);

    logic [DATA_W-1:0] buf_result [2];
    logic [RD_W-1:0]   buf_rd [2];
    logic              head;
    logic              tail;
    logic [1:0]        count;
    logic              pass;
    logic              accept;
    logic              push;
    logic              pop;

    cond_check u_cond (
        .cond (in_cond),
        .nzcv (nzcv),
        .pass (pass)
    );

    // in_ready looks only at occupancy, so out_ready never reaches it
    assign in_ready   = (count != 2'd2);
    assign out_valid  = (count != 2'd0);
    assign out_result = buf_result[head];
    assign out_rd     = buf_rd[head];

    assign accept = in_valid && in_ready;
    assign push   = accept && pass && in_wen;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_result[0] <= '0;
            buf_result[1] <= '0;
            buf_rd[0]     <= '0;
            buf_rd[1]     <= '0;
            head          <= 1'b0;
            tail          <= 1'b0;
            count         <= 2'd0;
        end else begin
            if (push) begin
                buf_result[tail] <= in_result;
                buf_rd[tail]     <= in_rd;
                tail             <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nzcv       <= 4'd0;
            skip_count <= '0;
        end else if (accept) begin
            if (pass && in_setflags) begin
                nzcv <= in_flag;
            end
            if (!pass && (skip_count != '1)) begin
                skip_count <= skip_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed checks for alu_writeback_stage: handshake, conditions,
// buffering, saturation and asynchronous reset.
module tb_alu_writeback_stage;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_flag;
    logic [3:0]  in_cond;
    logic        in_setflags;
    logic        in_wen;
    logic [3:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic [3:0]  nzcv;
    logic [15:0] skip_count;

    int tests;
    int fails;

    alu_writeback_stage #(
        .DATA_W (32),
        .RD_W   (4),
        .CNT_W  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_flag     (in_flag),
        .in_cond     (in_cond),
        .in_setflags (in_setflags),
        .in_wen      (in_wen),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .nzcv        (nzcv),
        .skip_count  (skip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] res, input logic [3:0] rd,
                         input logic [3:0] cond, input logic [3:0] flg,
                         input logic s, input logic wen);
        in_valid    = 1'b1;
        in_result   = res;
        in_rd       = rd;
        in_cond     = cond;
        in_flag     = flg;
        in_setflags = s;
        in_wen      = wen;
    endtask

    task automatic issue(input logic [31:0] res, input logic [3:0] rd,
                         input logic [3:0] cond, input logic [3:0] flg,
                         input logic s, input logic wen);
        drive(res, rd, cond, flg, s, wen);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_result   = '0;
        in_flag     = '0;
        in_cond     = '0;
        in_setflags = 1'b0;
        in_wen      = 1'b0;
        in_rd       = '0;
        out_ready   = 1'b0;

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_nzcv", 32'(nzcv), 32'd0);
        chk("rst_skip", 32'(skip_count), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // basic AL write
        out_ready = 1'b1;
        issue(32'h2D, 4'd3, COND_AL, 4'b0000, 1'b1, 1'b1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_result", out_result, 32'h2D);
        chk("t1_rd", 32'(out_rd), 32'd3);
        chk("t1_nzcv", 32'(nzcv), 32'd0);

        // SUBS sets Z,C; EQ passes, NE squashed
        issue(32'h99, 4'd1, COND_AL, 4'b0110, 1'b1, 1'b1);
        chk("t2_nzcv", 32'(nzcv), 32'b0110);
        chk("t2_subs_head", out_result, 32'h99);
        issue(32'h57, 4'd2, COND_EQ, 4'b0000, 1'b0, 1'b1);
        chk("t2_eq_result", out_result, 32'h57);
        chk("t2_eq_rd", 32'(out_rd), 32'd2);
        chk("t2_eq_valid", 32'(out_valid), 32'd1);
        issue(32'h1A, 4'd4, COND_NE, 4'b0000, 1'b0, 1'b1);
        chk("t2_ne_squashed", 32'(out_valid), 32'd0);
        chk("t2_skip", 32'(skip_count), 32'd1);
        chk("t2_nzcv_hold", 32'(nzcv), 32'b0110);

        // backpressure: fill, hold third, drain in order
        out_ready = 1'b0;
        issue(32'h101, 4'd5, COND_AL, 4'b0000, 1'b0, 1'b1);
        chk("t3_ready_1", 32'(in_ready), 32'd1);
        issue(32'h102, 4'd6, COND_AL, 4'b0000, 1'b0, 1'b1);
        chk("t3_ready_full", 32'(in_ready), 32'd0);
        drive(32'h103, 4'd7, COND_AL, 4'b0000, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_still_full", 32'(in_ready), 32'd0);
        chk("t3_head_result", out_result, 32'h101);
        chk("t3_head_rd", 32'(out_rd), 32'd5);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_drain2", out_result, 32'h102);
        chk("t3_drain2_rd", 32'(out_rd), 32'd6);
        chk("t3_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t3_drain3", out_result, 32'h103);
        chk("t3_drain3_rd", 32'(out_rd), 32'd7);
        chk("t3_drain3_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("t3_empty", 32'(out_valid), 32'd0);

        // streaming at count=1 with simultaneous push/pop
        out_ready = 1'b0;
        issue(32'h200, 4'd0, COND_AL, 4'b0000, 1'b0, 1'b1);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            issue(32'h200 + 32'(i), 4'(i), COND_AL, 4'b0000, 1'b0, 1'b1);
            chk("t4_head", out_result, 32'h200 + 32'(i));
            chk("t4_rd", 32'(out_rd), 32'(i));
            chk("t4_ready", 32'(in_ready), 32'd1);
            chk("t4_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        chk("t4_empty", 32'(out_valid), 32'd0);

        // saturation: NE fails while Z=1
        drive(32'hDEAD, 4'd9, COND_NE, 4'b1111, 1'b1, 1'b1);
        repeat (16'hFFFD) @(posedge clk);
        #1;
        chk("t5_preload", 32'(skip_count), 32'hFFFE);
        @(posedge clk);
        #1;
        chk("t5_sat1", 32'(skip_count), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("t5_sat2", 32'(skip_count), 32'hFFFF);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t5_sat3", 32'(skip_count), 32'hFFFF);
        chk("t5_no_push", 32'(out_valid), 32'd0);
        chk("t5_nzcv", 32'(nzcv), 32'b0110);

        // async reset mid-cycle with two entries buffered
        out_ready = 1'b0;
        issue(32'h301, 4'd7, COND_AL, 4'b1010, 1'b1, 1'b1);
        issue(32'h302, 4'd8, COND_AL, 4'b0000, 1'b0, 1'b1);
        chk("t6_pre_nzcv", 32'(nzcv), 32'b1010);
        chk("t6_pre_full", 32'(in_ready), 32'd0);
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_nzcv", 32'(nzcv), 32'd0);
        chk("t6_skip", 32'(skip_count), 32'd0);
        chk("t6_result", out_result, 32'd0);
        chk("t6_ready", 32'(in_ready), 32'd1);
        #2;
        reset = 1'b0;
        issue(32'h44, 4'd9, COND_AL, 4'b0101, 1'b1, 1'b1);
        chk("t6_after_valid", 32'(out_valid), 32'd1);
        chk("t6_after_result", out_result, 32'h44);
        chk("t6_after_nzcv", 32'(nzcv), 32'b0101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Downstream stage of `aluModule`: consumes each ALU `result` and `flag` {N,Z,C,V} and evaluates the instruction's condition code against the architectural NZCV register. If the condition passes, it updates NZCV when the instruction sets flags, and queues a register-file write in a 2-entry buffer with valid/ready handshakes. Failed-condition instructions are squashed and counted. The stage sits between the ALU and the register-file write port.

## Interface
- `DATA_W`, 32, result/write-data width
- `RD_W`, 4, destination register index width
- `CNT_W`, 16, squash counter width
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `in_valid`  in  1  ALU output valid this cycle
- `in_ready`  out  1  stage can accept; = (buffer count < 2)
- `in_result`  in  DATA_W  ALU `result`
- `in_flag`  in  4  ALU `flag`, bit3 N, bit2 Z, bit1 C, bit0 V
- `in_cond`  in  4  ARM condition field
- `in_setflags`  in  1  S bit: commit `in_flag` to NZCV on pass
- `in_wen`  in  1  instruction writes `in_rd` (0 for CMP/CMN/TST/TEQ)
- `in_rd`  in  RD_W  destination register
- `out_valid`  out  1  write entry available at buffer head
- `out_ready`  in  1  register file consumes head
- `out_result`  out  DATA_W  head write data
- `out_rd`  out  RD_W  head destination
- `nzcv`  out  4  architectural flags register
- `skip_count`  out  CNT_W  squashed instructions, saturating

## Operation
- Accept = `in_valid && in_ready` at a rising edge. Inputs are ignored when they are not accepted.
- `pass` is evaluated combinationally from `in_cond` and the current `nzcv` register, never from `in_flag`:
  - EQ(0) Z; NE(1) !Z; CS(2) C; CC(3) !C; MI(4) N; PL(5) !N; VS(6) V; VC(7) !V
  - HI(8) C&!Z; LS(9) !C|Z; GE(10) N==V; LT(11) N!=V; GT(12) !Z&(N==V); LE(13) Z|(N!=V)
  - AL(14) 1; 15 is treated as 1.
- Accept with `pass`=1:
  - if `in_setflags`, `nzcv` <= `in_flag`;
  - if `in_wen`, push {`in_result`,`in_rd`} into the buffer.
- Accept with `pass`=0: no flag update and no push. `skip_count` increments and holds at all-ones.
- An accepted instruction with `in_wen`=0 and `in_setflags`=0 has no effect other than consuming the handshake.
- Buffer is a 2-entry FIFO with head/tail pointers and a count 0..2.
  - Pop = `out_valid && out_ready`.
  - `out_valid` = (count != 0). `out_result`/`out_rd` always show the head entry; they are held stable while `out_valid && !out_ready`.
- `in_ready` depends only on count, never on `in_valid` or `out_ready`. This gives no combinational path from `out_ready` to `in_ready`.

## Timing
- Reset values: `nzcv`=0, `skip_count`=0, count=0, `out_valid`=0, `out_result`=0, `out_rd`=0, `in_ready`=1.
- Latency: an entry pushed at edge t is visible (`out_valid`=1) in the cycle after edge t. This is 1 cycle.
- Flag update at edge t is visible to the `pass` evaluation of an instruction accepted at edge t+1. Back-to-back dependent instructions therefore need no bubble.
- Simultaneous push and pop:
  - count=1: count stays 1, head advances, new entry becomes next.
  - count=0: push only; no pop is possible.
  - count=2: no push, because `in_ready`=0.
- Full (count=2): `in_ready`=0 even for squashed or `in_wen`=0 instructions.
- Pointers wrap modulo 2.
- `reset` asserted mid-operation: buffered entries are dropped, `nzcv` and `skip_count` are cleared, and outputs take reset values asynchronously. First accept is possible at the first edge after deassertion.

## Structure
- Shared package `alu_pkg`:
  - condition constants `COND_EQ` .. `COND_AL`;
  - flag bit indices `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- One combinational sub-module `cond_check` (inputs `cond`[3:0], `nzcv`[3:0]; output `pass`). It is reusable by the branch unit.
- FIFO, NZCV register and counter are inline in `alu_writeback_stage`.

## Test plan
- Reset, then accept result=0x0000002D, rd=3, cond=AL, wen=1, S=1, flag=4'b0000, with `out_ready`=1. Required: `out_valid`=1 next cycle with `out_result`=0x2D, `out_rd`=3, and `nzcv`=0000.
- Accept a SUBS with flag=4'b0110 (Z,C), S=1, wen=1, rd=1. Next cycle, accept cond=EQ result=0x57 rd=2, then cond=NE result=0x1A rd=4. Required: the EQ entry is written, the NE entry is squashed, and `skip_count`=1.
- Hold `out_ready`=0 and accept 3 AL writes. Required: `in_ready` drops after the 2nd accept, the 3rd is held by the source, and the head stays at the 1st entry. Release `out_ready`: entries drain in order 1, 2, 3.
- With count=1 and `out_ready`=1, accept every cycle for 8 cycles. Required: count stays 1, `in_ready` stays 1, and no entries are lost or reordered.
- Preload `skip_count`=0xFFFE via 0xFFFE failing instructions, then issue 3 more failing ones. Required: the count saturates at 0xFFFF.
- Assert `reset` for 3 ns mid-cycle with 2 entries buffered and `nzcv`=1010. Required: `out_valid`, `nzcv` and `skip_count` go to 0 immediately, without waiting for a clock edge.
